// File: rtl/pe_fp32_sched_if.sv
// Request, PE drive and result bundle for the FP32 dot-product issue controller.
// Pure wiring, no latency.
// Backpressure is carried by in_ready on the request side and res_ready on the result side.
interface pe_fp32_sched_if #(
  parameter int ID_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [159:0]    in_a;
  logic [159:0]    in_b;
  logic [ID_W-1:0] in_id;
  logic [159:0]    pe_a;
  logic [159:0]    pe_b;
  logic            pe_clk_cntr;
  logic [31:0]     pe_out;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_data;
  logic [ID_W-1:0] res_id;
  logic            busy;

  // Environment side: supplies requests and PE results, consumes results.
  modport master (
    output in_valid, in_a, in_b, in_id, pe_out, res_ready,
    input  in_ready, pe_a, pe_b, pe_clk_cntr, res_valid, res_data, res_id, busy
  );

  // Controller side.
  modport slave (
    input  in_valid, in_a, in_b, in_id, pe_out, res_ready,
    output in_ready, pe_a, pe_b, pe_clk_cntr, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/pe_fp32_sched.sv
// Issue controller and in-order result buffer for the 5-lane FP32 dot-product PE.
// Latency: request accepted in cycle c gives res_valid in c+7 (empty FIFO); one request per 2 cycles.
// Backpressure: in_ready drops in BEAT0 and whenever queued + in-flight results would exceed the FIFO.
module pe_fp32_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 4,
  parameter int PE_LAT     = 5
) (
  input logic            clk,
  input logic            rst,
  pe_fp32_sched_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [159:0]    pe_a_q, pe_a_d;
  logic [159:0]    pe_b_q, pe_b_d;
  logic            pe_clk_cntr_q, pe_clk_cntr_d;
  logic [ID_W-1:0] id_q, id_d;

  logic [PE_LAT-1:0] trk_vld_q, trk_vld_d;
  logic [ID_W-1:0]   trk_id_q [PE_LAT];
  logic [ID_W-1:0]   trk_id_d [PE_LAT];

  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   fifo_count_q, fifo_count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     mem_dat_q [FIFO_DEPTH];
  logic [31:0]     mem_dat_d [FIFO_DEPTH];
  logic [ID_W-1:0] mem_id_q  [FIFO_DEPTH];
  logic [ID_W-1:0] mem_id_d  [FIFO_DEPTH];

  logic credit_ok, in_rdy, accept, push, pop, res_vld, fifo_full;

  // Handshake qualifiers: a request needs a free slot counting both queued and in-flight results.
  always_comb begin
    credit_ok = ({1'b0, fifo_count_q} + {1'b0, inflight_q}) < SW'(FIFO_DEPTH);
    in_rdy    = !rst && (state_q != BEAT0) && credit_ok;
    accept    = bus.in_valid && in_rdy;
    push      = trk_vld_q[PE_LAT-1];
    res_vld   = (fifo_count_q != '0);
    pop       = res_vld && bus.res_ready;
    fifo_full = (fifo_count_q == CW'(FIFO_DEPTH));
  end

  // Issue FSM next state; operands and tag load only on accept so they hold across both beats.
  always_comb begin
    state_d = state_q;
    pe_a_d  = pe_a_q;
    pe_b_d  = pe_b_q;
    id_d    = id_q;
    case (state_q)
      IDLE:    if (accept) state_d = BEAT0;
      BEAT0:   state_d = BEAT1;
      BEAT1:   state_d = accept ? BEAT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      pe_a_d = bus.in_a;
      pe_b_d = bus.in_b;
      id_d   = bus.in_id;
    end
    pe_clk_cntr_d = (state_d == BEAT1);
  end

  // Tracker mirrors the PE pipeline: an entry enters on each first beat and reaches the tail with its result.
  always_comb begin
    trk_vld_d   = {trk_vld_q[PE_LAT-2:0], state_q == BEAT0};
    trk_id_d[0] = id_q;
    for (int i = 1; i < PE_LAT; i++) trk_id_d[i] = trk_id_q[i-1];
    inflight_d = inflight_q;
    case ({accept, push})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Result FIFO: capture from the PE at the tracker tail, release in order at the head.
  always_comb begin
    mem_dat_d    = mem_dat_q;
    mem_id_d     = mem_id_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push) begin
      mem_dat_d[wr_ptr_q] = bus.pe_out;
      mem_id_d[wr_ptr_q]  = trk_id_q[PE_LAT-1];
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // All state registers; reset also drops tracker entries so stale PE results are never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pe_a_q        <= '0;
      pe_b_q        <= '0;
      pe_clk_cntr_q <= 1'b0;
      id_q          <= '0;
      trk_vld_q     <= '0;
      for (int i = 0; i < PE_LAT; i++) trk_id_q[i] <= '0;
      inflight_q    <= '0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dat_q[i] <= '0;
        mem_id_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      pe_a_q        <= pe_a_d;
      pe_b_q        <= pe_b_d;
      pe_clk_cntr_q <= pe_clk_cntr_d;
      id_q          <= id_d;
      trk_vld_q     <= trk_vld_d;
      trk_id_q      <= trk_id_d;
      inflight_q    <= inflight_d;
      fifo_count_q  <= fifo_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_dat_q     <= mem_dat_d;
      mem_id_q      <= mem_id_d;
    end
  end

  // Credits make a capture into a full FIFO impossible; flag it if it ever happens.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full);

  assign bus.in_ready    = in_rdy;
  assign bus.pe_a        = pe_a_q;
  assign bus.pe_b        = pe_b_q;
  assign bus.pe_clk_cntr = pe_clk_cntr_q;
  assign bus.res_valid   = res_vld;
  assign bus.res_data    = res_vld ? mem_dat_q[rd_ptr_q] : 32'd0;
  assign bus.res_id      = res_vld ? mem_id_q[rd_ptr_q] : '0;
  assign bus.busy        = (state_q != IDLE) || (inflight_q != '0) || (fifo_count_q != '0);
endmodule

// File: tb/tb_pe_fp32_sched.sv
// Directed bench for pe_fp32_sched with a behavioural 5-stage PE model.
// Outputs are checked one time unit after the rising edge; inputs change at the same point.
// Results are drained with res_ready except where backpressure is being exercised.
module tb_pe_fp32_sched;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] MONE = 32'hBF800000;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  pe_fp32_sched_if #(.ID_W(4)) bus ();

  pe_fp32_sched #(.FIFO_DEPTH(4), .ID_W(4), .PE_LAT(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FP32 <-> real for normal numbers and zero, enough for the PE model.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] dot5(input logic [159:0] a, input logic [159:0] b);
    real s;
    s = 0.0;
    for (int k = 0; k < 5; k++) s = s + f2r(a[32*k +: 32]) * f2r(b[32*k +: 32]);
    return r2f(s);
  endfunction

  // PE model: result of the first-beat operands appears on pe_out five cycles later.
  logic [31:0] pipe [5];
  always @(posedge clk) begin
    pipe[0] <= bus.pe_clk_cntr ? 32'hDEADBEEF : dot5(bus.pe_a, bus.pe_b);
    for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.pe_out = pipe[4];

  // Transaction log: accept cycles and popped results.
  int          acc_q [$];
  int          rc_q  [$];
  logic [31:0] rd_q  [$];
  logic [3:0]  ri_q  [$];
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.res_valid && bus.res_ready) begin
        rc_q.push_back(cyc);
        rd_q.push_back(bus.res_data);
        ri_q.push_back(bus.res_id);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    acc_q.delete(); rc_q.delete(); rd_q.delete(); ri_q.delete();
  endtask

  task automatic issue(input logic [159:0] a, input logic [159:0] b, input logic [3:0] id,
                       output int acc_cyc);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_id = id;
    #1;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    acc_cyc = bus.in_ready ? cyc : -1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(input int bound, output int c, output logic [31:0] d, output logic [3:0] id);
    int n;
    c = -1; d = 32'd0; id = 4'd0; n = 0;
    while (c < 0 && n < bound) begin
      if (bus.res_valid) begin
        c = cyc; d = bus.res_data; id = bus.res_id;
      end
      step();
      n++;
    end
  endtask

  // Streaming driver: request j carries id id_base+j and lane0 A = fval[j], B = 1.0.
  logic [31:0] fval [8];
  int k, acc_base, id_base;

  task automatic drive_set(input int nmax);
    k = acc_q.size() - acc_base;
    bus.in_valid = (k < nmax);
    bus.in_id    = 4'(id_base + k);
    bus.in_a     = {128'd0, fval[(id_base + k) % 8]};
    bus.in_b     = {128'd0, ONE};
  endtask

  task automatic drive_cycles(input int ncyc, input int nmax);
    for (int i = 0; i < ncyc; i++) begin
      drive_set(nmax);
      step();
    end
    drive_set(nmax);
  endtask

  initial begin : main
    int t, c, s, p, spur;
    logic [31:0] d;
    logic [3:0]  id;
    logic [159:0] va, vb;

    fval[0] = 32'h3F800000; fval[1] = 32'h40000000; fval[2] = 32'h40400000; fval[3] = 32'h40800000;
    fval[4] = 32'h40A00000; fval[5] = 32'h40C00000; fval[6] = 32'h40E00000; fval[7] = 32'h41000000;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_id = '0; bus.res_ready = 1'b1;
    acc_base = 0; id_base = 0; k = 0;

    // Reset state
    step(); step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pe_clk_cntr", bus.pe_clk_cntr, 0);
    chk("rst_pe_a", bus.pe_a, 0);
    rst = 1'b0;
    #1;
    chk("first_in_ready", bus.in_ready, 1);
    step();

    // Single request: 2.0 * 3.0 = 6.0
    va = {128'd0, 32'h40000000}; vb = {128'd0, 32'h40400000};
    issue(va, vb, 4'd3, t);
    chk("single_pe_clk_c1", bus.pe_clk_cntr, 0);
    chk("single_pe_a_c1", bus.pe_a, va);
    chk("single_in_ready_beat0", bus.in_ready, 0);
    step();
    chk("single_pe_clk_c2", bus.pe_clk_cntr, 1);
    chk("single_pe_b_c2", bus.pe_b, vb);
    wait_res(20, c, d, id);
    chk("single_latency", c - t, 7);
    chk("single_data", d, 32'h40C00000);
    chk("single_id", id, 3);
    chk("single_busy_after_pop", bus.busy, 0);
    chk("single_res_valid_after_pop", bus.res_valid, 0);

    // Full vector: five lanes of 1.0*1.0, then lane 0 negated
    va = {5{ONE}}; vb = {5{ONE}};
    issue(va, vb, 4'd1, t);
    wait_res(20, c, d, id);
    chk("full_data", d, 32'h40A00000);
    chk("full_latency", c - t, 7);
    vb = {{4{ONE}}, MONE};
    issue(va, vb, 4'd2, t);
    wait_res(20, c, d, id);
    chk("neg_data", d, 32'h40400000);
    chk("neg_id", id, 2);

    // Streaming at full rate: eight requests, ids 0..7
    step();
    clear_log(); acc_base = 0; id_base = 0; bus.res_ready = 1'b1;
    s = cyc;
    drive_cycles(40, 8);
    chk("stream_accepts", acc_q.size(), 8);
    chk("stream_results", rc_q.size(), 8);
    for (int i = 0; i < 8 && i < acc_q.size() && i < rc_q.size(); i++) begin
      chk($sformatf("stream_acc_cyc%0d", i), acc_q[i] - s, 2 * i);
      chk($sformatf("stream_res_cyc%0d", i), rc_q[i] - s, 7 + 2 * i);
      chk($sformatf("stream_id%0d", i), ri_q[i], i);
      chk($sformatf("stream_data%0d", i), rd_q[i], fval[i]);
    end

    // Backpressure and credits
    clear_log(); acc_base = 0; id_base = 8; bus.res_ready = 1'b0;
    drive_cycles(20, 8);
    chk("bp_accepts", acc_q.size(), 4);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_res_valid", bus.res_valid, 1);
    chk("bp_head_id", bus.res_id, 8);
    chk("bp_head_data", bus.res_data, fval[0]);
    chk("bp_busy", bus.busy, 1);
    p = cyc;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    drive_cycles(3, 5);
    chk("bp_accepts_after_pop", acc_q.size(), 5);
    if (acc_q.size() >= 5) chk("bp_next_accept_cyc", acc_q[4] - p, 1);
    chk("bp_single_pop", rc_q.size(), 1);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("bp_drained", rc_q.size(), 5);
    for (int i = 0; i < rc_q.size() && i < 5; i++)
      chk($sformatf("bp_id%0d", i), ri_q[i], 8 + i);
    chk("bp_busy_end", bus.busy, 0);

    // Reset mid-operation: BEAT1 with two results queued and one in flight
    clear_log(); acc_base = 0; id_base = 0; bus.res_ready = 1'b0;
    drive_cycles(3, 2);
    for (int i = 0; i < 6; i++) step();
    chk("rm_two_queued", bus.res_valid, 1);
    issue({5{ONE}}, {5{ONE}}, 4'd5, t);
    step();
    chk("rm_in_beat1", bus.pe_clk_cntr, 1);
    rst = 1'b1;
    #1;
    chk("rm_pe_a", bus.pe_a, 0);
    chk("rm_pe_b", bus.pe_b, 0);
    chk("rm_pe_clk_cntr", bus.pe_clk_cntr, 0);
    chk("rm_res_valid", bus.res_valid, 0);
    chk("rm_res_data", bus.res_data, 0);
    chk("rm_res_id", bus.res_id, 0);
    chk("rm_in_ready", bus.in_ready, 0);
    chk("rm_busy", bus.busy, 0);
    step(); step();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    spur = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.res_valid) spur++;
      step();
    end
    chk("rm_no_spurious", spur, 0);
    issue({5{ONE}}, {{4{ONE}}, MONE}, 4'd9, t);
    wait_res(20, c, d, id);
    chk("rm_new_latency", c - t, 7);
    chk("rm_new_data", d, 32'h40400000);
    chk("rm_new_id", id, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
